// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the IF stage.
//   - default reset PC and fetch-buffer depth
//   - NOP encoding and branch-type codes shared with decode/EX
//   - fetch_entry_t: one buffered {pc, inst} pair
//   - pc_align(): force a PC to word alignment
package fetch_unit_pkg;

   localparam logic [31:0] DefResetPc   = 32'h0000_0000;
   localparam int unsigned DefFifoDepth = 2;
   localparam logic [31:0] InstNop      = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [2:0] {
      BrNone,
      BrBeq,
      BrBne,
      BrBlt,
      BrBge,
      BrBltu,
      BrBgeu,
      BrJump
   } br_type_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] pc_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the IF stage, instruction memory and decode.
//   imem_req_*  : fetch request channel (valid/ready, word address)
//   imem_resp_* : in-order response channel, no backpressure
//   if_*        : {pc, inst} handoff to decode (valid/ready)
// master = fetch unit view, slave = environment (imem + decode) view.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      output if_valid,
      output if_pc,
      output if_inst,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      input  if_valid,
      input  if_pc,
      input  if_inst,
      output if_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo: synchronous fetch buffer of DEPTH {pc, inst} entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push/push_data : write an entry at the tail
//   pop         : drop the head entry (caller guarantees non-empty)
//   flush       : empty the buffer; overrides push and pop
//   count       : number of valid entries
//   head_valid/head : head entry, read straight from storage flops
module fetch_unit_fifo
   import fetch_unit_pkg::*;
#(
   parameter  int unsigned DEPTH = DefFifoDepth,
   localparam int unsigned PtrW  = $clog2(DEPTH),
   localparam int unsigned CntW  = PtrW + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  fetch_entry_t    push_data,
   input  logic            pop,
   input  logic            flush,
   output logic [CntW-1:0] count,
   output logic            head_valid,
   output fetch_entry_t    head
);

   fetch_entry_t    mem_q [DEPTH];
   fetch_entry_t    mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Storage is reset too so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count      = count_q;
   assign head_valid = (count_q != '0);
   assign head       = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && !flush) begin
         assert (!(push && !pop && count_q == CntW'(DEPTH)))
            else $error("fetch_unit_fifo: push into full buffer");
         assert (!(pop && count_q == '0))
            else $error("fetch_unit_fifo: pop from empty buffer");
      end
   end
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the RV32I pipeline.
//   clk, rst_n      : clock, asynchronous active-low reset
//   branch_signal   : EX redirect strobe, single-cycle qualified
//   branch_target   : redirect PC (low two bits ignored)
//   bus (master)    : imem request/response channels and the {pc, inst} handoff to decode
// Owns the fetch PC, issues in-order word requests, tags returning words with their PC and
// buffers them for decode. A redirect flushes the buffer and turns every request still in
// flight into a stale one that is counted off and discarded on return.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DefResetPc,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         branch_signal,
   input  logic [31:0]  branch_target,
   fetch_unit_if.master bus
);

   localparam int unsigned OutW  = $clog2(FIFO_DEPTH) + 1;
   // Stale words can briefly exceed the buffer depth across back-to-back redirects.
   localparam int unsigned DropW = $clog2(FIFO_DEPTH) + 2;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [OutW-1:0]  outstanding_q, outstanding_d;  // live (non-stale) requests in flight
   logic [DropW-1:0] drop_cnt_q, drop_cnt_d;        // stale responses still to discard

   logic [OutW-1:0]  fifo_count;
   logic             fifo_head_valid;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;

   logic credit_ok;
   logic req_valid;
   logic fire;
   logic drop_now;
   logic live_resp;
   logic push;
   logic pop;

   // Every live request is guaranteed a buffer slot, so responses never need backpressure.
   assign credit_ok = (32'(outstanding_q) + 32'(fifo_count)) < FIFO_DEPTH;
   assign req_valid = rst_n & ~branch_signal & credit_ok;
   assign fire      = req_valid & bus.imem_req_ready;

   assign drop_now  = bus.imem_resp_valid & (drop_cnt_q != '0);
   assign live_resp = bus.imem_resp_valid & ~drop_now;
   assign push      = live_resp & ~branch_signal;
   assign pop       = fifo_head_valid & bus.if_ready & ~branch_signal;

   assign push_entry = '{pc: resp_pc_q, inst: bus.imem_resp_data};

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      if (branch_signal) begin
         pc_d          = pc_align(branch_target);
         resp_pc_d     = pc_align(branch_target);
         outstanding_d = '0;
         // Whatever returns this cycle retires one pending word, stale or live.
         drop_cnt_d    = drop_cnt_q + DropW'(outstanding_q) - DropW'(bus.imem_resp_valid);
      end else begin
         if (fire) begin
            pc_d = pc_q + 32'd4;
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
         end
         outstanding_d = outstanding_q + OutW'(fire) - OutW'(live_resp);
         if (drop_now) begin
            drop_cnt_d = drop_cnt_q - DropW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_unit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .flush      (branch_signal),
      .count      (fifo_count),
      .head_valid (fifo_head_valid),
      .head       (fifo_head)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.if_valid       = fifo_head_valid;
   assign bus.if_pc          = fifo_head.pc;
   assign bus.if_inst        = fifo_head.inst;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(bus.imem_resp_valid && outstanding_q == '0 && drop_cnt_q == '0))
            else $error("fetch_unit: response with nothing in flight");
         assert (32'(outstanding_q) <= FIFO_DEPTH)
            else $error("fetch_unit: outstanding overflow");
         assert (32'(drop_cnt_q) <= 2 * FIFO_DEPTH)
            else $error("fetch_unit: drop_cnt overflow");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural imem (in-order queue of requests with per-request latency) and a reference
// of the instruction stream decode should see: after reset or a redirect, consecutive word
// PCs from the (aligned) start address, each paired with mem_word(pc).
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int unsigned Depth   = 2;
   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        branch_signal;
   logic [31:0] branch_target;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (ResetPc),
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branch_signal (branch_signal),
      .branch_target (branch_target),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;
   int cyc;

   // imem model: requests in flight, oldest first
   logic [31:0] q_addr  [$];
   int          q_due   [$];
   bit          q_stale [$];
   int          lat_lo;
   int          lat_hi;

   // reference stream state
   int          buffered;   // words returned and not yet taken by decode
   logic [31:0] exp_req;    // next address the fetch unit should request
   logic [31:0] exp_dec;    // PC decode should see next

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_model();
      q_addr.delete();
      q_due.delete();
      q_stale.delete();
      buffered = 0;
      exp_req  = ResetPc;
      exp_dec  = ResetPc;
   endtask

   // Asserted off the clock edges to show the reset acts without a clock.
   task automatic do_reset();
      #3;
      rst_n                = 1'b0;
      branch_signal        = 1'b0;
      bus.imem_resp_valid  = 1'b0;
      #1;
      check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check_eq("rst_if_pc", bus.if_pc, 32'd0);
      check_eq("rst_if_inst", bus.if_inst, 32'd0);
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic step(input logic br, input logic [31:0] tgt, input logic dec_rdy,
                       input logic mem_rdy);
      int          live;
      logic        resp;
      logic        exp_rv;
      logic        fire;
      logic        pop;
      logic [31:0] fire_addr;
      int          due;

      branch_signal      = br;
      branch_target      = tgt;
      bus.if_ready       = dec_rdy;
      bus.imem_req_ready = mem_rdy;
      resp               = (q_due.size() > 0) && (q_due[0] <= cyc);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? mem_word(q_addr[0]) : $urandom();
      #1;
      live = 0;
      foreach (q_stale[i]) if (!q_stale[i]) live++;
      exp_rv = !br && ((live + buffered) < Depth);
      check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (bus.imem_req_valid) check_eq("req_addr", bus.imem_req_addr, exp_req);
      check_eq("if_valid", 32'(bus.if_valid), 32'(buffered > 0));
      if (bus.if_valid) begin
         check_eq("if_pc", bus.if_pc, exp_dec);
         check_eq("if_inst", bus.if_inst, mem_word(exp_dec));
      end
      fire      = bus.imem_req_valid & mem_rdy;
      pop       = bus.if_valid & dec_rdy;
      fire_addr = bus.imem_req_addr;

      @(posedge clk);
      if (resp) begin
         if (!q_stale[0] && !br) buffered++;
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
         void'(q_stale.pop_front());
      end
      if (br) begin
         buffered = 0;
         foreach (q_stale[i]) q_stale[i] = 1'b1;
         exp_req = tgt & 32'hFFFF_FFFC;
         exp_dec = tgt & 32'hFFFF_FFFC;
      end else begin
         if (pop) begin
            buffered--;
            exp_dec += 32'd4;
         end
         if (fire) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (q_due.size() > 0 && due <= q_due[$]) due = q_due[$] + 1;
            q_addr.push_back(fire_addr);
            q_due.push_back(due);
            q_stale.push_back(1'b0);
            exp_req += 32'd4;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      n_checks            = 0;
      n_errors            = 0;
      cyc                 = 0;
      rst_n               = 1'b0;
      branch_signal       = 1'b0;
      branch_target       = '0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.if_ready        = 1'b0;
      lat_lo              = 1;
      lat_hi              = 1;
      clear_model();

      do_reset();

      // streaming from reset, single-cycle memory
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);

      // decode stalls: buffer fills, requests stop, head holds
      repeat (10) step(1'b0, '0, 1'b0, 1'b1);
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);

      // redirect with requests in flight at latency 3
      lat_lo = 3;
      lat_hi = 3;
      repeat (6) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
      repeat (10) step(1'b0, '0, 1'b1, 1'b1);

      // redirect coinciding with a returning word and a decode pop
      lat_lo = 1;
      lat_hi = 1;
      repeat (6) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);

      // back-to-back redirects, last one wins, low target bits ignored
      lat_lo = 2;
      lat_hi = 2;
      repeat (5) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
      step(1'b1, 32'h0000_0303, 1'b1, 1'b1);
      repeat (10) step(1'b0, '0, 1'b1, 1'b1);

      // PC wrap past 0xFFFF_FFFC, then reset mid-stream
      lat_lo = 1;
      lat_hi = 1;
      step(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
      repeat (10) step(1'b0, '0, 1'b1, 1'b1);
      do_reset();
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);

      // randomized traffic
      lat_lo = 1;
      lat_hi = 3;
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 19) == 0), $urandom(), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
